// File: rtl/icache_l1_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : icache_l1_fill                                               |
// | Description : L1 instruction-cache miss table and line-fill stage. Merges  |
// |               duplicate line misses, issues L2 line reads tagged with the  |
// |               slot index, and returns fills to the L1 one cycle after the  |
// |               L2 response. Snoop invalidations mark in-flight lines as     |
// |               killed so their fills go out non-installable.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module icache_l1_fill #(
  parameter int NPHYS            = 56,
  parameter int ACACHE_LINE_SIZE = 6,
  parameter int CACHE_LINE_SIZE  = 512,
  parameter int NMISS            = 4,
  parameter int TRANS_ID_SIZE    = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  // fetch miss interface
  input  logic                               miss_req,
  input  logic [NPHYS-1:ACACHE_LINE_SIZE]    miss_addr,
  output logic                               miss_ack,
  output logic                               miss_full,
  // L2 read request
  output logic                               l2_req,
  output logic [NPHYS-1:ACACHE_LINE_SIZE]    l2_addr,
  output logic [TRANS_ID_SIZE-1:0]           l2_trid,
  input  logic                               l2_ack,
  // L2 read response
  input  logic                               l2_rdata_req,
  input  logic [CACHE_LINE_SIZE-1:0]         l2_rdata,
  input  logic [TRANS_ID_SIZE-1:0]           l2_rtrid,
  input  logic [2:0]                         l2_resp,
  // snoop
  input  logic                               ic_snoop_addr_req,
  input  logic [NPHYS-1:ACACHE_LINE_SIZE]    ic_snoop_addr,
  input  logic [1:0]                         ic_snoop_snoop,
  // L1 fill port
  output logic                               ic_rdata_req,
  output logic [CACHE_LINE_SIZE-1:0]         ic_rdata,
  output logic [NPHYS-1:ACACHE_LINE_SIZE]    ic_raddr,
  output logic [2:0]                         ic_rdata_resp
);

  localparam int IDX_W = (NMISS > 1) ? $clog2(NMISS) : 1;

  // Snoop encodings from the cache protocol (NONE=0, READ=1, READ_EXCLUSIVE=2,
  // READ_INVALID=3); only the two invalidating types matter here.
  localparam logic [1:0] SNOOP_READ_EXCLUSIVE = 2'd2;
  localparam logic [1:0] SNOOP_READ_INVALID   = 2'd3;

  // miss table state
  logic [NMISS-1:0]               valid_q, valid_d;
  logic [NMISS-1:0]               sent_q, sent_d;
  logic [NMISS-1:0]               killed_q, killed_d;
  logic [NPHYS-1:ACACHE_LINE_SIZE] addr_q [NMISS];
  logic [NPHYS-1:ACACHE_LINE_SIZE] addr_d [NMISS];

  // issue hold: keeps l2_addr/l2_trid stable until the request is taken
  logic                           hold_q, hold_d;
  logic [IDX_W-1:0]               hold_idx_q, hold_idx_d;

  // fill output registers
  logic                           ic_rdata_req_q, ic_rdata_req_d;
  logic [CACHE_LINE_SIZE-1:0]     ic_rdata_q, ic_rdata_d;
  logic [NPHYS-1:ACACHE_LINE_SIZE] ic_raddr_q, ic_raddr_d;
  logic [2:0]                     ic_rdata_resp_q, ic_rdata_resp_d;

  // lookup results
  logic [NMISS-1:0]               miss_hit;
  logic [NMISS-1:0]               snoop_hit;
  logic                           snoop_kill;
  logic                           free_found;
  logic [IDX_W-1:0]               free_idx;
  logic                           pend_found;
  logic [IDX_W-1:0]               pend_idx;
  logic [IDX_W-1:0]               issue_idx;
  logic                           alloc;
  logic [IDX_W-1:0]               rsp_idx;
  logic                           rsp_hit;
  logic                           rsp_killed;

  assign snoop_kill = ic_snoop_addr_req &&
                      ((ic_snoop_snoop == SNOOP_READ_EXCLUSIVE) ||
                       (ic_snoop_snoop == SNOOP_READ_INVALID));

  // Address compare of every valid entry against the miss and snoop addresses
  always_comb begin
    miss_hit  = '0;
    snoop_hit = '0;
    for (int i = 0; i < NMISS; i++) begin
      miss_hit[i]  = valid_q[i] && (addr_q[i] == miss_addr);
      snoop_hit[i] = snoop_kill && valid_q[i] && (addr_q[i] == ic_snoop_addr);
    end
  end

  // Lowest-index free slot and lowest-index unsent entry (pre-edge state)
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = NMISS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid_q[i] && !sent_q[i]) begin
        pend_found = 1'b1;
        pend_idx   = IDX_W'(i);
      end
    end
  end

  // Fetch handshake, L2 issue and response qualification
  always_comb begin
    miss_full = &valid_q;
    miss_ack  = miss_req && ((|miss_hit) || free_found);
    alloc     = miss_req && !(|miss_hit) && free_found;
    // A held request keeps its slot even if a lower slot becomes pending.
    issue_idx = hold_q ? hold_idx_q : pend_idx;
    l2_req    = pend_found;
    l2_addr   = addr_q[issue_idx];
    l2_trid   = TRANS_ID_SIZE'(issue_idx);
    rsp_idx   = l2_rtrid[IDX_W-1:0];
    rsp_hit   = l2_rdata_req && valid_q[rsp_idx] && sent_q[rsp_idx] &&
                ((l2_rtrid >> IDX_W) == '0);
    // A snoop arriving with the response still makes the fill non-installable.
    rsp_killed = killed_q[rsp_idx] | snoop_hit[rsp_idx];
  end

  // Miss table next state: issue, snoop kill, retire, allocate
  always_comb begin
    valid_d    = valid_q;
    sent_d     = sent_q;
    killed_d   = killed_q;
    addr_d     = addr_q;
    hold_d     = l2_req && !l2_ack;
    hold_idx_d = issue_idx;
    if (l2_req && l2_ack) begin
      sent_d[issue_idx] = 1'b1;
    end
    killed_d = killed_d | snoop_hit;
    if (rsp_hit) begin
      valid_d[rsp_idx]  = 1'b0;
      sent_d[rsp_idx]   = 1'b0;
      killed_d[rsp_idx] = 1'b0;
    end
    // New entries start unkilled: their read has not been issued yet.
    if (alloc) begin
      valid_d[free_idx]  = 1'b1;
      sent_d[free_idx]   = 1'b0;
      killed_d[free_idx] = 1'b0;
      addr_d[free_idx]   = miss_addr;
    end
  end

  // Fill to L1 one cycle after a qualified response
  always_comb begin
    ic_rdata_req_d  = rsp_hit;
    ic_rdata_d      = ic_rdata_q;
    ic_raddr_d      = ic_raddr_q;
    ic_rdata_resp_d = ic_rdata_resp_q;
    if (rsp_hit) begin
      ic_rdata_d      = l2_rdata;
      ic_raddr_d      = addr_q[rsp_idx];
      ic_rdata_resp_d = {l2_resp[2:1], l2_resp[0] & ~rsp_killed};
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      sent_q         <= '0;
      killed_q       <= '0;
      hold_q         <= 1'b0;
      hold_idx_q     <= '0;
      ic_rdata_req_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      sent_q         <= sent_d;
      killed_q       <= killed_d;
      hold_q         <= hold_d;
      hold_idx_q     <= hold_idx_d;
      ic_rdata_req_q <= ic_rdata_req_d;
    end
  end

  // Datapath registers, qualified by the valid bits above
  always_ff @(posedge clk) begin
    addr_q          <= addr_d;
    ic_rdata_q      <= ic_rdata_d;
    ic_raddr_q      <= ic_raddr_d;
    ic_rdata_resp_q <= ic_rdata_resp_d;
  end

  assign ic_rdata_req  = ic_rdata_req_q;
  assign ic_rdata      = ic_rdata_q;
  assign ic_raddr      = ic_raddr_q;
  assign ic_rdata_resp = ic_rdata_resp_q;

endmodule
`default_nettype wire
